ahb_slave_mem: RTL and testbench

Parametrised AHB-Lite memory slave for the AHB protocol testbench and the RTL bus fabric. It is the synthesisable successor to the flat slave-side signal bundle and adds configurable data width and depth, HSIZE-aware byte lanes with optional write strobes, and programmable wait states. It also adds a read-only region and the two-cycle AHB ERROR response. It sits behind the decoder/mux and drives HREADYOUT/HRESP for one slot.

---
 rtl/ahb_pkg.sv | 50 +++++
 rtl/ahb_mem_array.sv | 29 ++
 rtl/ahb_slave_mem.sv | 167 ++++++++++++++++
 tb/tb_ahb_slave_mem.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types and the byte-lane helper used by the memory slave.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE   = 3'd0,
        HSIZE_HALF   = 3'd1,
        HSIZE_WORD   = 3'd2,
        HSIZE_DWORD  = 3'd3,
        HSIZE_4WORD  = 3'd4,
        HSIZE_8WORD  = 3'd5,
        HSIZE_16WORD = 3'd6,
        HSIZE_32WORD = 3'd7
    } hsize_e;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } resp_e;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        DATA,
        ERR1,
        ERR2
    } state_e;

    localparam int MAX_LANES = 8;

    // Lanes touched by a transfer of 1<<size bytes starting at byte offset addr_lsb.
    function automatic logic [MAX_LANES-1:0] lane_mask(input logic [2:0] size,
                                                       input logic [2:0] addr_lsb);
        logic [MAX_LANES-1:0] base;
        case (size)
            3'd0:    base = 8'h01;
            3'd1:    base = 8'h03;
            3'd2:    base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << addr_lsb;
    endfunction

endpackage

// File: rtl/ahb_mem_array.sv
// Word-organised storage with per-byte write enables and an asynchronous read port.
module ahb_mem_array #(
    parameter int DEPTH      = 256,
    parameter int DATA_WIDTH = 32,
    localparam int NBYTES    = DATA_WIDTH / 8,
    localparam int IDX_BITS  = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic [NBYTES-1:0]     wen,
    input  logic [IDX_BITS-1:0]   waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [IDX_BITS-1:0]   raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset; contents survive rst and it maps onto plain RAM.
    always_ff @(posedge clk) begin
        for (int b = 0; b < NBYTES; b++) begin
            if (wen[b]) begin
                mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite memory slave: address-phase decode, wait-state/error FSM and data-phase context.
import ahb_pkg::*;

module ahb_slave_mem #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0,
    parameter int RO_WORDS    = 0,
    parameter int STRB_EN     = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sel,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [1:0]              trans,
    input  logic [2:0]              size,
    input  logic                    write,
    input  logic [3:0]              prot,
    input  logic [DATA_WIDTH/8-1:0] strb,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic                    ready_in,
    output logic                    ready,
    output logic                    slave_error,
    output logic [DATA_WIDTH-1:0]   rdata
);

    localparam int NBYTES    = DATA_WIDTH / 8;
    localparam int LANE_BITS = $clog2(NBYTES);
    localparam int IDX_BITS  = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH+1)'(DEPTH * NBYTES);
    localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
        $error("ahb_slave_mem: WAIT_STATES must be in 0..15");
    end
    if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_data_width
        $error("ahb_slave_mem: DATA_WIDTH must be 32 or 64");
    end

    state_e                state, next_state;
    logic [3:0]            wait_cnt, next_cnt;
    resp_e                 resp;
    logic                  load_ctx;
    logic                  ctx_write;
    logic [IDX_BITS-1:0]   ctx_idx;
    logic [NBYTES-1:0]     ctx_lanes;
    logic [NBYTES-1:0]     mem_wen;
    logic [DATA_WIDTH-1:0] mem_rdata;

    logic                  accept, acc_err, ro_region;
    logic                  addr_oor, size_bad, misalign;
    logic [7:0]            align_mask;
    logic [MAX_LANES-1:0]  lanes_all;

    // Address-phase decode; evaluated only when accept is high.
    always_comb begin
        accept     = sel && ready_in && (htrans_e'(trans) inside {HTRANS_NONSEQ, HTRANS_SEQ});
        addr_oor   = {1'b0, addr} >= MEM_LIMIT;
        size_bad   = size > 3'(LANE_BITS);
        align_mask = (8'd1 << size) - 8'd1;
        misalign   = |(align_mask[2:0] & addr[2:0]);
        acc_err    = addr_oor || size_bad || misalign || (write && ro_region);
        lanes_all  = lane_mask(size, 3'(addr[LANE_BITS-1:0]));
    end

    if (RO_WORDS > 0) begin : g_ro
        localparam logic [ADDR_WIDTH:0] RO_LIMIT = (ADDR_WIDTH+1)'(RO_WORDS);
        logic [ADDR_WIDTH:0] word_full;
        assign word_full = {1'b0, addr} >> LANE_BITS;
        assign ro_region = word_full < RO_LIMIT;
    end else begin : g_no_ro
        assign ro_region = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            ctx_write <= 1'b0;
            ctx_idx   <= '0;
            ctx_lanes <= '0;
        end else begin
            state    <= next_state;
            wait_cnt <= next_cnt;
            if (load_ctx) begin
                ctx_write <= write;
                ctx_idx   <= addr[LANE_BITS +: IDX_BITS];
                ctx_lanes <= lanes_all[NBYTES-1:0];
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        next_state = state;
        next_cnt   = wait_cnt;
        ready      = 1'b1;
        resp       = HRESP_OKAY;
        load_ctx   = 1'b0;
        case (state)
            IDLE, DATA, ERR2: begin
                if (state == ERR2) begin
                    resp = HRESP_ERROR;
                end
                if (accept) begin
                    load_ctx = 1'b1;
                    if (acc_err) begin
                        next_state = ERR1;
                    end else if (WAIT_STATES > 0) begin
                        next_state = WAIT;
                        next_cnt   = WS_LOAD;
                    end else begin
                        next_state = DATA;
                    end
                end else begin
                    next_state = IDLE;
                end
            end
            WAIT: begin
                ready = 1'b0;
                if (wait_cnt == 4'd0) begin
                    next_state = DATA;
                end else begin
                    next_cnt = wait_cnt - 4'd1;
                end
            end
            ERR1: begin
                ready      = 1'b0;
                resp       = HRESP_ERROR;
                next_state = ERR2;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign slave_error = (resp == HRESP_ERROR);

    // A write commits only in its DATA cycle; a coincident rst drops it.
    always_comb begin
        mem_wen = '0;
        if (state == DATA && ctx_write && !rst) begin
            mem_wen = ctx_lanes & ((STRB_EN != 0) ? strb : {NBYTES{1'b1}});
        end
    end

    assign rdata = (state == DATA && !ctx_write) ? mem_rdata : '0;

    ahb_mem_array #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mem (
        .clk   (clk),
        .wen   (mem_wen),
        .waddr (ctx_idx),
        .wdata (wdata),
        .raddr (ctx_idx),
        .rdata (mem_rdata)
    );

    logic unused_inputs;
    assign unused_inputs = ^{prot, lanes_all};

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Directed AHB-Lite bench: a pipelined master model feeds a scoreboard of expected responses.
module tb_ahb_slave_mem;
    import ahb_pkg::*;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          sel0, sel1;
    logic [AW-1:0] addr;
    logic [1:0]    trans;
    logic [2:0]    size;
    logic          write;
    logic [3:0]    prot;
    logic [3:0]    strb;
    logic [DW-1:0] wdata;
    logic          rdy0, rdy1, err0, err1;
    logic [DW-1:0] rd0, rd1;

    always #5 clk = ~clk;

    // dut0: zero wait, 4 read-only words, strobes ignored
    ahb_slave_mem #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH),
        .WAIT_STATES(0), .RO_WORDS(4), .STRB_EN(0)
    ) u_dut0 (
        .clk(clk), .rst(rst), .sel(sel0), .addr(addr), .trans(trans), .size(size),
        .write(write), .prot(prot), .strb(strb), .wdata(wdata), .ready_in(rdy0),
        .ready(rdy0), .slave_error(err0), .rdata(rd0)
    );

    // dut1: three wait states, no read-only region, strobes honoured
    ahb_slave_mem #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH),
        .WAIT_STATES(3), .RO_WORDS(0), .STRB_EN(1)
    ) u_dut1 (
        .clk(clk), .rst(rst), .sel(sel1), .addr(addr), .trans(trans), .size(size),
        .write(write), .prot(prot), .strb(strb), .wdata(wdata), .ready_in(rdy1),
        .ready(rdy1), .slave_error(err1), .rdata(rd1)
    );

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic [31:0] addr;
        logic [2:0]  size;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } xfer_t;

    typedef struct {
        int          id;
        logic        err;
        logic        rd;
        logic        chk;
        logic [31:0] rdata;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          len;
    } exp_t;

    xfer_t       seq[$];
    exp_t        sb[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    int          next_id  = 0;
    logic [31:0] model_mem [2][DEPTH];
    bit          model_ok  [2][DEPTH];

    task automatic check(input string tag, input int id, input logic [31:0] got,
                         input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s (ref %0d): observed %h expected %h", tag, id, got, exp);
        end
    endtask

    function automatic void add(input logic s, input logic [1:0] t, input logic [31:0] a,
                                input logic [2:0] sz, input logic w, input logic [31:0] wd,
                                input logic [3:0] st);
        xfer_t x;
        x.sel = s; x.trans = t; x.addr = a; x.size = sz;
        x.wr = w; x.wdata = wd; x.strb = st;
        seq.push_back(x);
    endfunction

    // Reference behaviour of an accepted transfer; writes update the shadow memory at once.
    function automatic exp_t model_accept(input int d, input xfer_t x);
        exp_t        e;
        logic [3:0]  lanes;
        logic [31:0] ro_lim;
        int          idx;
        ro_lim  = (d == 0) ? 32'd4 : 32'd0;
        e.id    = next_id;
        next_id++;
        e.rd    = !x.wr;
        e.wdata = x.wdata;
        e.strb  = x.strb;
        e.rdata = '0;
        e.chk   = 1'b0;
        e.err   = (x.addr >= 32'd1024) || (x.size > 3'd2) ||
                  ((x.addr & ((32'd1 << x.size) - 32'd1)) != 32'd0) ||
                  (x.wr && ((x.addr >> 2) < ro_lim));
        e.len   = e.err ? 2 : ((d == 0) ? 1 : 4);
        idx     = int'(x.addr[9:2]);
        if (!e.err) begin
            if (x.wr) begin
                lanes = (x.size == 3'd0) ? 4'b0001 : (x.size == 3'd1) ? 4'b0011 : 4'b1111;
                lanes = lanes << x.addr[1:0];
                if (d == 1) lanes = lanes & x.strb;
                for (int b = 0; b < 4; b++) begin
                    if (lanes[b]) model_mem[d][idx][8*b +: 8] = x.wdata[8*b +: 8];
                end
                if (lanes == 4'hF) model_ok[d][idx] = 1'b1;
            end else begin
                e.rdata = model_mem[d][idx];
                e.chk   = model_ok[d][idx];
            end
        end
        return e;
    endfunction

    // Pipelined master: holds each address phase until ready, drives wdata of the open data phase.
    task automatic run(input int d);
        int   ai     = 0;
        int   dp_cyc = 0;
        int   guard  = 0;
        logic r, er, accepted;
        logic [31:0] rdv;
        exp_t e;
        while ((ai < seq.size() || sb.size() != 0) && guard < 400) begin
            guard++;
            if (ai < seq.size()) begin
                if (d == 0) sel0 = seq[ai].sel; else sel1 = seq[ai].sel;
                trans = seq[ai].trans;
                addr  = seq[ai].addr;
                size  = seq[ai].size;
                write = seq[ai].wr;
            end else begin
                sel0 = 1'b0; sel1 = 1'b0;
                trans = HTRANS_IDLE;
            end
            if (sb.size() != 0) begin
                wdata = sb[0].wdata;
                strb  = sb[0].strb;
            end else begin
                wdata = $urandom;
                strb  = 4'($urandom);
            end
            @(negedge clk);
            r   = (d == 0) ? rdy0 : rdy1;
            er  = (d == 0) ? err0 : err1;
            rdv = (d == 0) ? rd0  : rd1;
            if (sb.size() != 0) begin
                dp_cyc++;
                if (r) begin
                    e = sb.pop_front();
                    check("resp_err", e.id, 32'(er), 32'(e.err));
                    check("phase_len", e.id, dp_cyc, e.len);
                    if (e.rd && !e.err && e.chk) check("rdata", e.id, rdv, e.rdata);
                    else if (!e.rd || e.err)      check("rdata_zero", e.id, rdv, 32'd0);
                    dp_cyc = 0;
                end else begin
                    check("stall_err", sb[0].id, 32'(er), 32'(sb[0].err));
                    check("stall_rdata", sb[0].id, rdv, 32'd0);
                end
            end else begin
                check("idle_ready", d, 32'(r), 32'd1);
                check("idle_err", d, 32'(er), 32'd0);
                check("idle_rdata", d, rdv, 32'd0);
            end
            accepted = r && (ai < seq.size());
            @(posedge clk);
            #1;
            if (accepted) begin
                if (seq[ai].sel && seq[ai].trans[1]) sb.push_back(model_accept(d, seq[ai]));
                ai++;
            end
        end
        check("drained", d, 32'(sb.size() + seq.size() - ai), 32'd0);
        sb.delete();
        seq.delete();
        sel0 = 1'b0; sel1 = 1'b0;
        trans = HTRANS_IDLE;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; sel0 = 1'b0; sel1 = 1'b0; addr = '0; trans = HTRANS_IDLE;
        size = 3'd0; write = 1'b0; prot = 4'b0011; strb = '0; wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready0", 0, 32'(rdy0), 32'd1);
        check("rst_err0", 0, 32'(err0), 32'd0);
        check("rst_rdata0", 0, rd0, 32'd0);
        check("rst_ready1", 1, 32'(rdy1), 32'd1);
        check("rst_err1", 1, 32'(err1), 32'd0);
        check("rst_rdata1", 1, rd1, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // write then read of the same word, zero wait
        add(1, HTRANS_NONSEQ, 32'h10, HSIZE_WORD, 1, 32'hA5A5_0001, 4'h0);
        add(1, HTRANS_NONSEQ, 32'h10, HSIZE_WORD, 0, 32'h0, 4'h0);
        run(0);

        // wait states on both write and read
        add(1, HTRANS_NONSEQ, 32'h04, HSIZE_WORD, 1, 32'h1234_5678, 4'hF);
        add(1, HTRANS_NONSEQ, 32'h04, HSIZE_WORD, 0, 32'h0, 4'hF);
        run(1);

        // byte lanes, misaligned halfword error, pipelined accept in ERR2
        add(1, HTRANS_NONSEQ, 32'h20, HSIZE_WORD, 1, 32'h1122_3344, 4'h0);
        add(1, HTRANS_NONSEQ, 32'h22, HSIZE_HALF, 1, 32'hBEEF_BEEF, 4'h0);
        add(1, HTRANS_NONSEQ, 32'h20, HSIZE_WORD, 0, 32'h0, 4'h0);
        add(1, HTRANS_NONSEQ, 32'h21, HSIZE_HALF, 1, 32'h1234_1234, 4'h0);
        add(1, HTRANS_NONSEQ, 32'h20, HSIZE_WORD, 0, 32'h0, 4'h0);
        add(1, HTRANS_NONSEQ, 32'h23, HSIZE_BYTE, 1, 32'h5A5A_5A5A, 4'h0);
        add(1, HTRANS_NONSEQ, 32'h20, HSIZE_WORD, 0, 32'h0, 4'h0);
        run(0);

        // read-only region, range, size and alignment errors, deselected transfer
        add(1, HTRANS_NONSEQ, 32'h08, HSIZE_WORD, 1, 32'hFFFF_FFFF, 4'h0);
        add(1, HTRANS_NONSEQ, 32'h08, HSIZE_WORD, 0, 32'h0, 4'h0);
        add(1, HTRANS_NONSEQ, 32'h400, HSIZE_WORD, 0, 32'h0, 4'h0);
        add(1, HTRANS_NONSEQ, 32'h0C, HSIZE_DWORD, 0, 32'h0, 4'h0);
        add(1, HTRANS_NONSEQ, 32'h12, HSIZE_WORD, 0, 32'h0, 4'h0);
        add(0, HTRANS_NONSEQ, 32'h10, HSIZE_WORD, 1, 32'h0BAD_0BAD, 4'h0);
        add(1, HTRANS_IDLE, 32'h10, HSIZE_WORD, 1, 32'h0BAD_0BAD, 4'h0);
        add(1, HTRANS_NONSEQ, 32'h3FC, HSIZE_WORD, 1, 32'h7777_0000, 4'h0);
        add(1, HTRANS_NONSEQ, 32'h3FC, HSIZE_WORD, 0, 32'h0, 4'h0);
        add(1, HTRANS_NONSEQ, 32'h10, HSIZE_WORD, 0, 32'h0, 4'h0);
        run(0);

        // burst writes and reads with BUSY bubbles
        add(1, HTRANS_NONSEQ, 32'h40, HSIZE_WORD, 1, 32'h1000_0000, 4'h0);
        add(1, HTRANS_SEQ,    32'h44, HSIZE_WORD, 1, 32'h1000_0001, 4'h0);
        add(1, HTRANS_BUSY,   32'h48, HSIZE_WORD, 1, 32'hDEAD_DEAD, 4'h0);
        add(1, HTRANS_SEQ,    32'h48, HSIZE_WORD, 1, 32'h1000_0002, 4'h0);
        add(1, HTRANS_SEQ,    32'h4C, HSIZE_WORD, 1, 32'h1000_0003, 4'h0);
        add(1, HTRANS_NONSEQ, 32'h40, HSIZE_WORD, 0, 32'h0, 4'h0);
        add(1, HTRANS_SEQ,    32'h44, HSIZE_WORD, 0, 32'h0, 4'h0);
        add(1, HTRANS_BUSY,   32'h48, HSIZE_WORD, 0, 32'h0, 4'h0);
        add(1, HTRANS_SEQ,    32'h48, HSIZE_WORD, 0, 32'h0, 4'h0);
        add(1, HTRANS_SEQ,    32'h4C, HSIZE_WORD, 0, 32'h0, 4'h0);
        run(0);

        // strobes narrow the derived lanes
        add(1, HTRANS_NONSEQ, 32'h04, HSIZE_WORD, 1, 32'hCAFE_F00D, 4'b0011);
        add(1, HTRANS_NONSEQ, 32'h04, HSIZE_WORD, 0, 32'h0, 4'hF);
        add(1, HTRANS_NONSEQ, 32'h07, HSIZE_BYTE, 1, 32'h9999_9999, 4'hF);
        add(1, HTRANS_NONSEQ, 32'h04, HSIZE_WORD, 0, 32'h0, 4'hF);
        run(1);

        // reset lands in the WAIT phase of a write; that write must be lost
        sel1 = 1'b1; trans = HTRANS_NONSEQ; addr = 32'h04; size = HSIZE_WORD; write = 1'b1;
        @(posedge clk);
        #1;
        sel1 = 1'b0; trans = HTRANS_IDLE; wdata = 32'hDEAD_BEEF; strb = 4'hF;
        @(negedge clk);
        check("rst_mid_stall", 1, 32'(rdy1), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_ready", 1, 32'(rdy1), 32'd1);
        check("rst_mid_err", 1, 32'(err1), 32'd0);
        check("rst_mid_rdata", 1, rd1, 32'd0);
        @(posedge clk);
        #1;
        add(1, HTRANS_NONSEQ, 32'h04, HSIZE_WORD, 0, 32'h0, 4'hF);
        run(1);
        add(1, HTRANS_NONSEQ, 32'h10, HSIZE_WORD, 0, 32'h0, 4'h0);
        run(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
